// File: rtl/my_pkg.sv
// my_pkg: shared state encoding, random-word field layout and modulo helper for the GA crossover stage.
package my_pkg;
   typedef enum logic [2:0] {LOAD, COPY, FILL, MUTATE, OUT} xo_states_e;
   localparam int RAND_W = 40;
   localparam int C1_LSB = 0;
   localparam int C2_LSB = 8;
   localparam int CH_LSB = 16;
   localparam int M1_LSB = 24;
   localparam int M2_LSB = 32;
   function automatic logic [7:0] mod_n(input logic [7:0] field, input int n);
      return 8'(32'(field) % n);
   endfunction
endpackage

// File: rtl/ga_crossover_mutate.sv
// ga_crossover_mutate: OX1 crossover of two parent routes plus optional swap mutation, child streamed out.
module ga_crossover_mutate
   import my_pkg::*;
#(
   parameter int NUM_CITIES = 10,
   parameter int GENE_W     = 8,
   parameter int MUT_THRESH = 26
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              par_valid,
   output logic              par_ready,
   input  logic [GENE_W-1:0] par_a_gene,
   input  logic [GENE_W-1:0] par_b_gene,
   input  logic [RAND_W-1:0] rand_in,
   output logic              child_valid,
   input  logic              child_ready,
   output logic [GENE_W-1:0] child_gene,
   output logic              child_last,
   output logic              mutated,
   output logic              busy
);
   localparam int PW = $clog2(NUM_CITIES);
   localparam logic [PW-1:0] LAST = PW'(NUM_CITIES - 1);
   logic [GENE_W-1:0] r_a [NUM_CITIES];
   logic [GENE_W-1:0] r_b [NUM_CITIES];
   logic [GENE_W-1:0] r_child [NUM_CITIES];
   logic [NUM_CITIES-1:0] r_used;
   xo_states_e r_state, w_nxt;
   logic [PW-1:0] r_k, r_q, r_p, r_hi, r_s, r_w, r_cnt, r_m1, r_m2;
   logic r_mut_en, r_mut;
   logic [PW-1:0] w_c1, w_c2, w_lo, w_hi, w_start;
   logic [GENE_W-1:0] w_cp_gene, w_fill_gene;
   logic w_ld, w_cp_ok, w_fill_wr, w_out_hs;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
      return (v == LAST) ? '0 : v + 1'b1;
   endfunction
   assign w_c1 = PW'(mod_n(rand_in[C1_LSB +: 8], NUM_CITIES));
   assign w_c2 = PW'(mod_n(rand_in[C2_LSB +: 8], NUM_CITIES));
   assign w_lo = (w_c1 < w_c2) ? w_c1 : w_c2;
   assign w_hi = (w_c1 < w_c2) ? w_c2 : w_c1;
   assign w_start = inc(r_hi);
   assign w_cp_gene = r_a[r_p];
   assign w_fill_gene = r_b[r_s];
   // genes outside 0..N-1 (malformed parents) are never marked used, so the FSM still completes
   assign w_cp_ok = (r_state == COPY) && (32'(w_cp_gene) < NUM_CITIES);
   assign w_fill_wr = (r_state == FILL) && (32'(w_fill_gene) < NUM_CITIES) && !r_used[w_fill_gene[PW-1:0]];
   assign w_ld = par_valid && par_ready;
   assign w_out_hs = child_valid && child_ready;
   always_comb begin
      w_nxt = r_state;
      par_ready = RESET && (r_state == LOAD);
      child_valid = (r_state == OUT);
      child_gene = child_valid ? r_child[r_q] : '0;
      child_last = child_valid && (r_q == LAST);
      mutated = r_mut;
      busy = (r_state != LOAD);
      case (r_state)
         LOAD:    if (par_valid && r_k == LAST) w_nxt = COPY;
         COPY:    if (r_p == r_hi) w_nxt = FILL;
         FILL:    if (r_cnt == LAST) w_nxt = MUTATE;
         MUTATE:  w_nxt = OUT;
         OUT:     if (child_ready && r_q == LAST) w_nxt = LOAD;
         default: w_nxt = LOAD;
      endcase
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= LOAD;
         r_used <= '0;
         r_k <= '0;
         r_q <= '0;
         r_p <= '0;
         r_hi <= '0;
         r_s <= '0;
         r_w <= '0;
         r_cnt <= '0;
         r_m1 <= '0;
         r_m2 <= '0;
         r_mut_en <= 1'b0;
         r_mut <= 1'b0;
      end else begin
         r_state <= w_nxt;
         case (r_state)
            LOAD: if (w_ld) begin
               r_k <= inc(r_k);
               if (r_k == LAST) begin
                  r_p <= w_lo;
                  r_hi <= w_hi;
                  r_m1 <= PW'(mod_n(rand_in[M1_LSB +: 8], NUM_CITIES));
                  r_m2 <= PW'(mod_n(rand_in[M2_LSB +: 8], NUM_CITIES));
                  r_mut_en <= 32'(rand_in[CH_LSB +: 8]) < MUT_THRESH;
               end
            end
            COPY: begin
               if (w_cp_ok) r_used[w_cp_gene[PW-1:0]] <= 1'b1;
               r_p <= r_p + 1'b1;
               r_s <= w_start;
               r_w <= w_start;
               r_cnt <= '0;
            end
            FILL: begin
               if (w_fill_wr) begin
                  r_used[w_fill_gene[PW-1:0]] <= 1'b1;
                  r_w <= inc(r_w);
               end
               r_s <= inc(r_s);
               r_cnt <= r_cnt + 1'b1;
            end
            MUTATE: r_mut <= r_mut_en;
            OUT: if (w_out_hs) begin
               r_q <= inc(r_q);
               if (r_q == LAST) begin
                  r_used <= '0;
                  r_k <= '0;
                  r_mut <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
   // route storage needs no reset: it is always fully rewritten before being read
   always_ff @(posedge CLK) begin
      if (w_ld) begin
         r_a[r_k] <= par_a_gene;
         r_b[r_k] <= par_b_gene;
      end
      if (r_state == COPY) r_child[r_p] <= w_cp_gene;
      if (w_fill_wr) r_child[r_w] <= w_fill_gene;
      if (r_state == MUTATE && r_mut_en) begin
         r_child[r_m1] <= r_child[r_m2];
         r_child[r_m2] <= r_child[r_m1];
      end
   end
endmodule

// File: tb/tb_ga_crossover_mutate.sv
// tb_ga_crossover_mutate: scoreboard bench for the OX1 crossover/mutation stage with N=8.
module tb_ga_crossover_mutate;
   localparam int N = 8;
   typedef int route_t [N];
   typedef struct {int gene; bit last; bit mut;} exp_t;
   logic CLK, RESET, par_valid, par_ready, child_valid, child_ready, child_last, mutated, busy;
   logic [7:0] par_a_gene, par_b_gene, child_gene;
   logic [39:0] rand_in;
   int n_checks = 0;
   int n_fail = 0;
   exp_t exp_q[$];
   exp_t e;
   bit held = 0;
   logic [7:0] held_g;
   bit bp_en = 0;
   logic [3:0] pat = 4'b1001;
   int bi = 0;
   route_t a, b, c;
   bit m;
   int lat;

   ga_crossover_mutate #(.NUM_CITIES(N), .GENE_W(8), .MUT_THRESH(26)) dut (
      .CLK(CLK), .RESET(RESET), .par_valid(par_valid), .par_ready(par_ready),
      .par_a_gene(par_a_gene), .par_b_gene(par_b_gene), .rand_in(rand_in),
      .child_valid(child_valid), .child_ready(child_ready), .child_gene(child_gene),
      .child_last(child_last), .mutated(mutated), .busy(busy)
   );

   initial CLK = 0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] mk(int c1, int c2, int ch, int m1, int m2);
      return {8'(m2), 8'(m1), 8'(ch), 8'(c2), 8'(c1)};
   endfunction

   task automatic ox_model(input route_t pa, input route_t pb, input logic [39:0] r,
                           output route_t pc, output bit pm, output int pl);
      int c1, c2, lo, hi, s, w, t, m1, m2;
      bit used [N];
      c1 = int'(r[7:0]) % N;
      c2 = int'(r[15:8]) % N;
      m1 = int'(r[31:24]) % N;
      m2 = int'(r[39:32]) % N;
      lo = (c1 < c2) ? c1 : c2;
      hi = (c1 < c2) ? c2 : c1;
      pc = '{default: 0};
      used = '{default: 0};
      for (int p = lo; p <= hi; p++) begin
         pc[p] = pa[p];
         used[pa[p]] = 1;
      end
      s = (hi + 1) % N;
      w = s;
      for (int i = 0; i < N; i++) begin
         if (!used[pb[s]]) begin
            pc[w] = pb[s];
            used[pb[s]] = 1;
            w = (w + 1) % N;
         end
         s = (s + 1) % N;
      end
      pm = int'(r[23:16]) < 26;
      if (pm) begin
         t = pc[m1];
         pc[m1] = pc[m2];
         pc[m2] = t;
      end
      pl = hi - lo + 1 + N + 1;
   endtask

   always @(negedge CLK) begin
      if (!RESET) held = 0;
      else if (child_valid) begin
         if (held) check("hold", child_gene, held_g);
         if (child_ready) begin
            if (exp_q.size() == 0) check("extra_beat", child_valid, 0);
            else begin
               e = exp_q.pop_front();
               check("gene", child_gene, e.gene);
               check("last", child_last, e.last);
               check("mutated", mutated, e.mut);
            end
         end
         held = !child_ready;
         held_g = child_gene;
      end else held = 0;
   end

   initial begin
      child_ready = 1;
      forever begin
         @(posedge CLK);
         #1;
         if (bp_en) begin
            child_ready = pat[bi];
            bi = (bi + 1) % 4;
         end else child_ready = 1;
      end
   end

   task automatic load_pair(input route_t pa, input route_t pb, input logic [39:0] r);
      for (int k = 0; k < N; k++) begin
         int t = 0;
         @(negedge CLK);
         par_valid = 1;
         par_a_gene = 8'(pa[k]);
         par_b_gene = 8'(pb[k]);
         rand_in = (k == N - 1) ? r : {8'($urandom), $urandom};
         while (!par_ready && t < 50) begin
            @(negedge CLK);
            t++;
         end
         if (!par_ready) check("par_ready_wait", par_ready, 1);
         @(posedge CLK);
         #1 par_valid = 0;
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 500) begin
         @(negedge CLK);
         t++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic run_pair(input route_t pa, input route_t pb, input logic [39:0] r,
                           input route_t ec, input bit em, input int el);
      int cnt = 0;
      for (int p = 0; p < N; p++) exp_q.push_back('{ec[p], p == N - 1, em});
      load_pair(pa, pb, r);
      while (cnt < 200) begin
         @(negedge CLK);
         if (child_valid) break;
         @(posedge CLK);
         cnt++;
      end
      check("latency", cnt, el);
      wait_done();
   endtask

   initial begin
      RESET = 0;
      par_valid = 0;
      par_a_gene = 0;
      par_b_gene = 0;
      rand_in = 0;
      repeat (3) @(negedge CLK);
      check("rst_par_ready", par_ready, 0);
      check("rst_child_valid", child_valid, 0);
      check("rst_child_last", child_last, 0);
      check("rst_mutated", mutated, 0);
      check("rst_busy", busy, 0);
      check("rst_child_gene", child_gene, 0);
      RESET = 1;
      @(negedge CLK);
      check("par_ready_idle", par_ready, 1);
      a = '{0, 1, 2, 3, 4, 5, 6, 7};
      b = '{7, 6, 5, 4, 3, 2, 1, 0};
      run_pair(a, b, mk(2, 5, 255, 0, 0), '{7, 6, 2, 3, 4, 5, 1, 0}, 0, 13);
      run_pair(a, b, mk(13, 2, 255, 0, 0), '{7, 6, 2, 3, 4, 5, 1, 0}, 0, 13);
      run_pair(a, b, mk(2, 5, 0, 0, 7), '{0, 6, 2, 3, 4, 5, 1, 7}, 1, 13);
      run_pair(a, b, mk(0, 7, 255, 0, 0), a, 0, 17);
      run_pair(a, b, mk(3, 3, 255, 1, 2), '{6, 5, 4, 3, 2, 1, 0, 7}, 0, 10);
      bp_en = 1;
      run_pair(a, b, mk(2, 5, 255, 0, 0), '{7, 6, 2, 3, 4, 5, 1, 0}, 0, 13);
      bp_en = 0;
      load_pair(a, b, mk(2, 5, 255, 0, 0));
      repeat (6) @(posedge CLK);
      @(negedge CLK);
      check("busy_fill", busy, 1);
      RESET = 0;
      #1;
      check("abort_child_valid", child_valid, 0);
      check("abort_par_ready", par_ready, 0);
      check("abort_busy", busy, 0);
      @(negedge CLK);
      RESET = 1;
      @(negedge CLK);
      check("release_par_ready", par_ready, 1);
      run_pair(a, b, mk(2, 5, 0, 0, 7), '{0, 6, 2, 3, 4, 5, 1, 7}, 1, 13);
      for (int i = 0; i < 4; i++) begin
         logic [39:0] r;
         for (int j = N - 1; j > 0; j--) begin
            int x, t;
            x = $urandom_range(j, 0);
            t = a[j]; a[j] = a[x]; a[x] = t;
            x = $urandom_range(j, 0);
            t = b[j]; b[j] = b[x]; b[x] = t;
         end
         r = {8'($urandom), $urandom};
         if (i[0]) r[23:16] = 8'($urandom_range(25, 0));
         ox_model(a, b, r, c, m, lat);
         run_pair(a, b, r, c, m, lat);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
